lane_distributor: RTL and testbench

//  Parametrised lane splitter/rotator for the STMC datapath, generalising the 2-way toggle divider.
//  - Takes a word of NUM_CH lanes (LANE_W bits each), of which the first in_cnt lanes are valid.
//  - Steers each valid lane to an output channel chosen by a rotation pointer.
//  - Advances the pointer once per non-empty beat, so load spreads across neuron-controller channels.
//  - Has a valid/ready handshake on both sides and a registered output.

---
 rtl/lane_dist_pkg.sv | 18 +
 rtl/lane_dist_skid.sv | 40 ++++
 rtl/lane_distributor.sv | 123 ++++++++++++
 tb/tb_lane_distributor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_dist_pkg.sv
// Shared encodings and index helpers for lane_distributor and its skid buffer.
package lane_dist_pkg;

    localparam int STEP_ONE  = 0;
    localparam int STEP_PACK = 1;

    function automatic int cnt_clamp(input int cnt, input int num_ch);
        return (cnt > num_ch) ? num_ch : cnt;
    endfunction

    // Callers keep i + ptr below 2*num_ch, so one conditional subtract is a true modulo.
    function automatic int ch_index(input int i, input int ptr, input int num_ch);
        int sum;
        sum = i + ptr;
        return (sum >= num_ch) ? (sum - num_ch) : sum;
    endfunction

endpackage

// File: rtl/lane_dist_skid.sv
// One-entry valid/ready skid buffer; upstream ready is registered and never sees downstream ready.
module lane_dist_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    assign o_ready = ~r_full & ~clr;
    assign o_valid = r_full | (i_valid & ~clr);
    assign o_data  = r_full ? r_data : i_data;

    // A stored beat always leaves before any newer one, which keeps beat order intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (clr) begin
            r_full <= 1'b0;
        end else if (r_full) begin
            if (i_ready) begin
                r_full <= 1'b0;
            end
        end else if (i_valid && !i_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/lane_distributor.sv
// Lane splitter/rotator: steers valid lanes to channels chosen by a rotating pointer.
// Define LANE_DIST_SKID_EN to place a 1-entry skid buffer on the input (registered in_ready).
module lane_distributor
    import lane_dist_pkg::*;
#(
    parameter  int LANE_W    = 16,
    parameter  int NUM_CH    = 2,
    parameter  int STEP_MODE = STEP_ONE,
    localparam int CW        = $clog2(NUM_CH + 1),
    localparam int PW        = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*LANE_W-1:0] in_data,
    input  logic [CW-1:0]            in_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*LANE_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_mask,
    output logic [PW-1:0]            rot_ptr
);

    localparam int DW = NUM_CH * LANE_W;

    logic              w_bValid;
    logic [DW-1:0]     w_bData;
    logic [CW-1:0]     w_bCnt;
    logic              w_stageReady;
    logic              w_take;
    logic [CW-1:0]     w_n;
    logic [CW-1:0]     w_step;
    logic [PW-1:0]     w_nextPtr;
    logic [DW-1:0]     w_mapData;
    logic [NUM_CH-1:0] w_mapMask;

    logic              r_outValid;
    logic [DW-1:0]     r_outData;
    logic [NUM_CH-1:0] r_outMask;
    logic [PW-1:0]     r_ptr;

    assign w_stageReady = ~r_outValid | out_ready;

`ifdef LANE_DIST_SKID_EN
    logic [DW+CW-1:0] w_skidOut;

    lane_dist_skid #(
        .W (DW + CW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({in_cnt, in_data}),
        .o_valid (w_bValid),
        .i_ready (w_stageReady),
        .o_data  (w_skidOut)
    );

    assign {w_bCnt, w_bData} = w_skidOut;
`else
    assign in_ready = ~clr & w_stageReady;
    assign w_bValid = in_valid;
    assign w_bData  = in_data;
    assign w_bCnt   = in_cnt;
`endif

    assign w_take    = w_bValid & w_stageReady & ~clr;
    assign w_n       = CW'(cnt_clamp(int'(w_bCnt), NUM_CH));
    assign w_step    = (STEP_MODE == STEP_PACK) ? w_n : CW'(1);
    assign w_nextPtr = PW'(ch_index(int'(w_step), int'(r_ptr), NUM_CH));

    // Each channel looks for the single valid lane that rotates onto it; none means zero.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [LANE_W-1:0] w_lane;
        logic              w_hit;

        always_comb begin
            w_lane = '0;
            w_hit  = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if ((i < int'(w_n)) && (ch_index(i, int'(r_ptr), NUM_CH) == c)) begin
                    w_lane = w_bData[i*LANE_W +: LANE_W];
                    w_hit  = 1'b1;
                end
            end
        end

        assign w_mapData[c*LANE_W +: LANE_W] = w_lane;
        assign w_mapMask[c]                  = w_hit;
    end

    // Empty beats are consumed without touching the pointer or producing an output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outMask  <= '0;
            r_ptr      <= '0;
        end else if (clr) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outMask  <= '0;
            r_ptr      <= '0;
        end else if (w_take && (w_n != '0)) begin
            r_outValid <= 1'b1;
            r_outData  <= w_mapData;
            r_outMask  <= w_mapMask;
            r_ptr      <= w_nextPtr;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_mask  = r_outMask;
    assign rot_ptr   = r_ptr;

endmodule

// File: tb/tb_lane_distributor.sv
// Self-checking bench: four lane_distributor configurations share one stimulus stream
// and are compared against a per-configuration queue model of the lane rotation rules.
module tb_lane_distributor;

    localparam int NI = 4;
    localparam int LW = 16;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  mask;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic [63:0] inData = '0;
    logic [2:0]  inCnt = '0;
    logic [1:0]  cntSmall;

    logic [31:0] aData;  logic [1:0] aMask; logic       aPtr;
    logic [63:0] bData;  logic [3:0] bMask; logic [1:0] bPtr;
    logic [63:0] cData;  logic [3:0] cMask; logic [1:0] cPtr;
    logic [47:0] dData;  logic [2:0] dMask; logic [1:0] dPtr;

    logic [63:0] obsData  [NI];
    logic [3:0]  obsMask  [NI];
    logic [1:0]  obsPtr   [NI];
    logic        obsValid [NI];
    logic        obsReady [NI];

    beat_t       expQ [NI][$];
    int          mPtr [NI];
    int          popCnt [NI];
    logic        lastAccept [NI];

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    assign cntSmall = (inCnt > 3'd3) ? 2'd3 : inCnt[1:0];

    lane_distributor #(.LANE_W(16), .NUM_CH(2), .STEP_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(obsReady[0]),
        .in_data(inData[31:0]), .in_cnt(cntSmall), .out_valid(obsValid[0]), .out_ready(outReady),
        .out_data(aData), .out_mask(aMask), .rot_ptr(aPtr));

    lane_distributor #(.LANE_W(16), .NUM_CH(4), .STEP_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(obsReady[1]),
        .in_data(inData), .in_cnt(inCnt), .out_valid(obsValid[1]), .out_ready(outReady),
        .out_data(bData), .out_mask(bMask), .rot_ptr(bPtr));

    lane_distributor #(.LANE_W(16), .NUM_CH(4), .STEP_MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(obsReady[2]),
        .in_data(inData), .in_cnt(inCnt), .out_valid(obsValid[2]), .out_ready(outReady),
        .out_data(cData), .out_mask(cMask), .rot_ptr(cPtr));

    lane_distributor #(.LANE_W(16), .NUM_CH(3), .STEP_MODE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(inValid), .in_ready(obsReady[3]),
        .in_data(inData[47:0]), .in_cnt(cntSmall), .out_valid(obsValid[3]), .out_ready(outReady),
        .out_data(dData), .out_mask(dMask), .rot_ptr(dPtr));

    assign obsData[0] = {32'h0, aData};
    assign obsData[1] = bData;
    assign obsData[2] = cData;
    assign obsData[3] = {16'h0, dData};
    assign obsMask[0] = {2'b0, aMask};
    assign obsMask[1] = bMask;
    assign obsMask[2] = cMask;
    assign obsMask[3] = {1'b0, dMask};
    assign obsPtr[0]  = {1'b0, aPtr};
    assign obsPtr[1]  = bPtr;
    assign obsPtr[2]  = cPtr;
    assign obsPtr[3]  = dPtr;

    function automatic int nchOf(input int k);
        case (k)
            0:       return 2;
            3:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int stepOf(input int k);
        return (k >= 2) ? 1 : 0;
    endfunction

    // Count as each instance's in_cnt port sees it (2-bit ports saturate at 3).
    function automatic int portCnt(input int k, input logic [2:0] c);
        if (nchOf(k) == 4) return int'(c);
        return (c > 3'd3) ? 3 : int'(c);
    endfunction

    function automatic beat_t modelBeat(input int k, input logic [63:0] d, input int n, input int ptr);
        beat_t b;
        b = '0;
        for (int i = 0; i < n; i++) begin
            int ch;
            ch = (i + ptr) % nchOf(k);
            b.data[ch*LW +: LW] = d[i*LW +: LW];
            b.mask[ch] = 1'b1;
        end
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < NI; k++) begin
            expQ[k].delete();
            mPtr[k] = 0;
            lastAccept[k] = 1'b0;
        end
    endtask

    // One cycle: drive at the falling edge, then score what the previous rising edge produced.
    task automatic applyStimulus(input logic v, input logic [2:0] cnt, input logic [63:0] d,
                                 input logic rdy, input logic c);
        @(negedge clk);
        inValid  = v;
        inCnt    = cnt;
        inData   = d;
        outReady = rdy;
        clr      = c;
        #1;
        for (int k = 0; k < NI; k++) begin
            logic expValid;
            int   n;
            expValid = (expQ[k].size() != 0);
            checkOutput($sformatf("rot_ptr[%0d]", k), 64'(obsPtr[k]), 64'(mPtr[k]));
            checkOutput($sformatf("out_valid[%0d]", k), 64'(obsValid[k]), 64'(expValid));
            if (obsValid[k] && expValid) begin
                checkOutput($sformatf("out_data[%0d]", k), obsData[k], expQ[k][0].data);
                checkOutput($sformatf("out_mask[%0d]", k), 64'(obsMask[k]), 64'(expQ[k][0].mask));
                if (rdy) begin
                    void'(expQ[k].pop_front());
                    popCnt[k]++;
                end
            end
`ifndef LANE_DIST_SKID_EN
            checkOutput($sformatf("in_ready[%0d]", k), 64'(obsReady[k]), 64'(!c && (!expValid || rdy)));
`else
            if (c) checkOutput($sformatf("in_ready_clr[%0d]", k), 64'(obsReady[k]), 64'(0));
`endif
            lastAccept[k] = 1'b0;
            if (c) begin
                expQ[k].delete();
                mPtr[k] = 0;
            end else if (v && obsReady[k]) begin
                lastAccept[k] = 1'b1;
                n = portCnt(k, cnt);
                if (n > nchOf(k)) n = nchOf(k);
                if (n > 0) begin
                    expQ[k].push_back(modelBeat(k, d, n, mPtr[k]));
                    mPtr[k] = (mPtr[k] + ((stepOf(k) == 1) ? n : 1)) % nchOf(k);
                end
            end
        end
    endtask

    initial begin
        int          b;
        int          stallAcc;
        int          pop0;
        logic [63:0] bpData;
        logic        rdy;

        for (int k = 0; k < NI; k++) popCnt[k] = 0;
        clearModel();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a held output beat.
        applyStimulus(1'b1, 3'd2, 64'h4444_3333_2222_1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("rst_valid[%0d]", k), 64'(obsValid[k]), 64'(0));
            checkOutput($sformatf("rst_mask[%0d]", k), 64'(obsMask[k]), 64'(0));
            checkOutput($sformatf("rst_data[%0d]", k), obsData[k], 64'(0));
            checkOutput($sformatf("rst_ptr[%0d]", k), 64'(obsPtr[k]), 64'(0));
        end
        clearModel();
        @(negedge clk);
        outReady = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NI; k++)
            checkOutput($sformatf("rst_in_ready[%0d]", k), 64'(obsReady[k]), 64'(1));

        // Two-lane toggle on the NUM_CH=2 instance.
        applyStimulus(1'b1, 3'd2, 64'h0000_0000_BBBB_AAAA, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd2, 64'h0000_0000_BBBB_AAAA, 1'b1, 1'b0);
        checkOutput("t2_beat1_data", obsData[0], 64'h0000_0000_BBBB_AAAA);
        checkOutput("t2_beat1_mask", 64'(obsMask[0]), 64'h3);
        checkOutput("t2_ptr_after1", 64'(obsPtr[0]), 64'h1);
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        checkOutput("t2_beat2_data", obsData[0], 64'h0000_0000_AAAA_BBBB);
        checkOutput("t2_ptr_after2", 64'(obsPtr[0]), 64'h0);

        // clr with a beat offered: refused, pointer and output cleared.
        applyStimulus(1'b1, 3'd2, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
        checkOutput("clr_in_ready", 64'(obsReady[1]), 64'(0));
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        checkOutput("clr_out_valid", 64'(obsValid[1]), 64'(0));
        checkOutput("clr_rot_ptr", 64'(obsPtr[1]), 64'(0));

        // Single lane at pointer 3 on NUM_CH=4 wraps the pointer to 0.
        repeat (3) applyStimulus(1'b1, 3'd1, 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd1, 64'h0000_0000_0000_1234, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        checkOutput("t3_data", obsData[1], 64'h1234_0000_0000_0000);
        checkOutput("t3_mask", 64'(obsMask[1]), 64'h8);
        checkOutput("t3_ptr_wrap", 64'(obsPtr[1]), 64'h0);

        // Packing step: pointer 2, three lanes.
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd2, 64'h0000_0000_0002_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd3, 64'h0000_000C_000B_000A, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        checkOutput("t4_data", obsData[2], 64'h000B_000A_0000_000C);
        checkOutput("t4_mask", 64'(obsMask[2]), 64'hD);
        checkOutput("t4_ptr", 64'(obsPtr[2]), 64'h1);

        // Empty beat is dropped, then an oversize count is clamped.
        applyStimulus(1'b1, 3'd0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        checkOutput("cnt0_no_beat", 64'(obsValid[2]), 64'(0));
        checkOutput("cnt0_ptr_kept", 64'(obsPtr[2]), 64'h1);
        applyStimulus(1'b1, 3'd5, 64'h4444_3333_2222_1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        checkOutput("cnt5_mask", 64'(obsMask[1]), 64'hF);
        checkOutput("cnt5_data", obsData[2], 64'h3333_2222_1111_4444);
        checkOutput("cnt5_ptr", 64'(obsPtr[2]), 64'h1);

        // Six-beat stream with a three-cycle stall in the middle.
        b = 0;
        stallAcc = 0;
        pop0 = popCnt[1];
        bpData = {$urandom, $urandom};
        for (int cyc = 0; cyc < 40 && (b < 6 || expQ[1].size() != 0); cyc++) begin
            rdy = !(cyc >= 3 && cyc < 6);
            applyStimulus(b < 6, 3'd4, bpData, rdy, 1'b0);
            if (lastAccept[1]) begin
                b++;
                if (!rdy) stallAcc++;
                bpData = {$urandom, $urandom};
            end
        end
        checkOutput("bp_beats_in", 64'(b), 64'(6));
        checkOutput("bp_beats_out", 64'(popCnt[1] - pop0), 64'(6));
`ifdef LANE_DIST_SKID_EN
        checkOutput("bp_stall_accepts", 64'(stallAcc), 64'(1));
`else
        checkOutput("bp_stall_accepts", 64'(stallAcc), 64'(0));
`endif

        // Randomized traffic with backpressure and occasional clears.
        for (int cyc = 0; cyc < 400; cyc++) begin
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 5)),
                          {$urandom, $urandom}, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 39) == 0);
        end

        repeat (6) applyStimulus(1'b0, 3'd0, 64'h0, 1'b1, 1'b0);
        for (int k = 0; k < NI; k++)
            checkOutput($sformatf("drained[%0d]", k), 64'(expQ[k].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
